// File: rtl/rf_wb_arbiter_pkg.sv
// rf_arb_pkg: shared widths and writeback source encoding for the writeback arbiter
package rf_arb_pkg;
    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    typedef enum logic {WB_SRC_A, WB_SRC_B} wb_src_e;
endpackage

// File: rtl/rf_wb_arbiter_if.sv
// rf_wb_arbiter_if: producer requests, register-file write drive and scoreboard lookup signals
interface rf_wb_arbiter_if;
    import rf_arb_pkg::*;
    logic                  a_valid;
    logic [REG_ADDR_W-1:0] a_rd;
    logic [XLEN-1:0]       a_data;
    logic                  a_ready;
    logic                  b_valid;
    logic [REG_ADDR_W-1:0] b_rd;
    logic [XLEN-1:0]       b_data;
    logic                  b_ready;
    logic                  stall;
    logic                  rf_we;
    logic [REG_ADDR_W-1:0] rf_rd;
    logic [XLEN-1:0]       rf_data;
    logic                  issue_valid;
    logic [REG_ADDR_W-1:0] issue_rd;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic                  hazard;

    modport slave (
        input  a_valid, a_rd, a_data, b_valid, b_rd, b_data, stall,
               issue_valid, issue_rd, rs1, rs2,
        output a_ready, b_ready, rf_we, rf_rd, rf_data, hazard
    );

    modport master (
        output a_valid, a_rd, a_data, b_valid, b_rd, b_data, stall,
               issue_valid, issue_rd, rs1, rs2,
        input  a_ready, b_ready, rf_we, rf_rd, rf_data, hazard
    );
endinterface

// File: rtl/rf_wb_arbiter_scoreboard.sv
// rf_scoreboard: pending port-B destination bits with set-over-clear priority and RAW lookup
module rf_scoreboard
    import rf_arb_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  i_set_en,
    input  logic [REG_ADDR_W-1:0] i_set_idx,
    input  logic                  i_clr_en,
    input  logic [REG_ADDR_W-1:0] i_clr_idx,
    input  logic [REG_ADDR_W-1:0] i_rs1,
    input  logic [REG_ADDR_W-1:0] i_rs2,
    output logic                  o_hazard
);
    localparam logic [NUM_REGS-1:0] X0_MASK = {{(NUM_REGS-1){1'b1}}, 1'b0};

    logic [NUM_REGS-1:0] r_sb;
    logic [NUM_REGS-1:0] w_set;
    logic [NUM_REGS-1:0] w_clr;

    // Decode set and clear indices into one-hot masks
    always_comb begin
        w_set = '0;
        w_clr = '0;
        if (i_set_en) w_set[i_set_idx] = 1'b1;
        if (i_clr_en) w_clr[i_clr_idx] = 1'b1;
    end

    // Set is applied after clear so it wins; x0 can never be pending
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_sb <= '0;
        else          r_sb <= ((r_sb & ~w_clr) | w_set) & X0_MASK;
    end

    assign o_hazard = r_sb[i_rs1] | r_sb[i_rs2];
endmodule

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: two-port register-file writeback arbiter with B starvation guard; optional scoreboard under RF_WB_ARB_SCOREBOARD_EN
module rf_wb_arbiter
    import rf_arb_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input logic              clk,
    input logic              reset_n,
    rf_wb_arbiter_if.slave   bus
);
    localparam logic [3:0] MAX_W = 4'(MAX_WAIT);

    logic [3:0]            r_wait_cnt;
    logic                  r_rf_we;
    logic [REG_ADDR_W-1:0] r_rf_rd;
    logic [XLEN-1:0]       r_rf_data;
    logic                  w_force_b;
    logic                  w_a_acc;
    logic                  w_b_acc;
    logic                  w_acc;
    logic                  w_wr;
    logic [REG_ADDR_W-1:0] w_rd;
    logic [XLEN-1:0]       w_data;

    // A has priority unless B has been denied MAX_WAIT times in a row
    always_comb begin
        w_force_b   = bus.b_valid && (r_wait_cnt == MAX_W);
        bus.a_ready = !bus.stall && !w_force_b;
        bus.b_ready = !bus.stall && bus.b_valid && (!bus.a_valid || w_force_b);
        w_a_acc     = bus.a_valid && bus.a_ready;
        w_b_acc     = bus.b_valid && bus.b_ready;
        w_acc       = w_a_acc || w_b_acc;
        w_rd        = w_b_acc ? bus.b_rd : bus.a_rd;
        w_data      = w_b_acc ? bus.b_data : bus.a_data;
        w_wr        = w_acc && (w_rd != '0);
    end

    // Count consecutive denied B cycles, frozen while stalled
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_wait_cnt <= '0;
        else if (!bus.stall) begin
            if (w_b_acc)                                r_wait_cnt <= '0;
            else if (bus.b_valid && r_wait_cnt != MAX_W) r_wait_cnt <= r_wait_cnt + 4'd1;
        end
    end

`ifdef RF_WB_ARB_SCOREBOARD_EN
    wb_src_e r_src_b;
`endif

    // Register the winning write; everything holds during stall so it retires once stall drops
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rf_we   <= 1'b0;
            r_rf_rd   <= '0;
            r_rf_data <= '0;
`ifdef RF_WB_ARB_SCOREBOARD_EN
            r_src_b   <= WB_SRC_A;
`endif
        end else if (!bus.stall) begin
            r_rf_we <= w_wr;
            if (w_wr) begin
                r_rf_rd   <= w_rd;
                r_rf_data <= w_data;
`ifdef RF_WB_ARB_SCOREBOARD_EN
                r_src_b   <= w_b_acc ? WB_SRC_B : WB_SRC_A;
`endif
            end
        end
    end

    assign bus.rf_we   = r_rf_we;
    assign bus.rf_rd   = r_rf_rd;
    assign bus.rf_data = r_rf_data;

`ifdef RF_WB_ARB_SCOREBOARD_EN
    rf_scoreboard u_sb (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_set_en  (bus.issue_valid && bus.issue_rd != '0),
        .i_set_idx (bus.issue_rd),
        .i_clr_en  (r_rf_we && !bus.stall && r_src_b == WB_SRC_B),
        .i_clr_idx (r_rf_rd),
        .i_rs1     (bus.rs1),
        .i_rs2     (bus.rs2),
        .o_hazard  (bus.hazard)
    );
`else
    logic w_unused;
    assign w_unused   = ^{bus.issue_valid, bus.issue_rd, bus.rs1, bus.rs2};
    assign bus.hazard = 1'b0;
`endif
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter: directed vectors with a write scoreboard queue checked by a retire monitor
module tb_rf_wb_arbiter;
    localparam int MAX_WAIT = 4;
`ifdef RF_WB_ARB_SCOREBOARD_EN
    localparam bit SB_ON = 1'b1;
`else
    localparam bit SB_ON = 1'b0;
`endif

    logic clk;
    logic reset_n;
    int   nchecks = 0;
    int   nfail   = 0;
    logic [36:0] exp_q[$];
    logic [36:0] e;

    rf_wb_arbiter_if bus();

    rf_wb_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Retire monitor: every retired write must match the oldest expected write
    always @(negedge clk) begin
        if (reset_n && bus.rf_we && !bus.stall) begin
            if (exp_q.size() == 0) begin
                nchecks++;
                nfail++;
                $display("FAIL unexpected_write actual=rd%0d/%h required=none", bus.rf_rd, bus.rf_data);
            end else begin
                e = exp_q.pop_front();
                chk("wr_rd", {27'd0, bus.rf_rd}, {27'd0, e[36:32]});
                chk("wr_data", bus.rf_data, e[31:0]);
            end
        end
    end

    task automatic cyc(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                       input logic bv, input logic [4:0] brd, input logic [31:0] bd,
                       input logic st, input logic iv, input logic [4:0] ird,
                       input logic [4:0] r1, input logic [4:0] r2,
                       input logic ear, input logic ebr, input logic ehz, input string nm);
        bus.a_valid = av; bus.a_rd = ard; bus.a_data = ad;
        bus.b_valid = bv; bus.b_rd = brd; bus.b_data = bd;
        bus.stall = st; bus.issue_valid = iv; bus.issue_rd = ird;
        bus.rs1 = r1; bus.rs2 = r2;
        @(negedge clk);
        chk({nm, "_a_ready"}, {31'd0, bus.a_ready}, {31'd0, ear});
        chk({nm, "_b_ready"}, {31'd0, bus.b_ready}, {31'd0, ebr});
        chk({nm, "_hazard"}, {31'd0, bus.hazard}, {31'd0, SB_ON ? ehz : 1'b0});
        if (ear && av && ard != 5'd0) exp_q.push_back({ard, ad});
        if (ebr && brd != 5'd0) exp_q.push_back({brd, bd});
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic [4:0] r1, input logic [4:0] r2, input logic ehz, input string nm);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, r1, r2, 1, 0, ehz, nm);
    endtask

    initial begin
        reset_n = 1'b0;
        bus.a_valid = 0; bus.a_rd = 0; bus.a_data = 0;
        bus.b_valid = 0; bus.b_rd = 0; bus.b_data = 0;
        bus.stall = 0; bus.issue_valid = 0; bus.issue_rd = 0;
        bus.rs1 = 0; bus.rs2 = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rf_we", {31'd0, bus.rf_we}, 0);
        chk("rst_rf_rd", {27'd0, bus.rf_rd}, 0);
        chk("rst_rf_data", bus.rf_data, 0);
        chk("rst_hazard", {31'd0, bus.hazard}, 0);
        reset_n = 1'b1;

        // Reset while a write is held on the port discards it immediately
        cyc(1, 3, 32'h55, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, "pre_rst");
        chk("pre_rst_we", {31'd0, bus.rf_we}, 1);
        reset_n = 1'b0;
        #1;
        chk("midrst_rf_we", {31'd0, bus.rf_we}, 0);
        chk("midrst_rf_rd", {27'd0, bus.rf_rd}, 0);
        chk("midrst_rf_data", bus.rf_data, 0);
        exp_q.delete();
        bus.a_valid = 0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        cyc(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, "first_a");
        chk("first_a_we", {31'd0, bus.rf_we}, 1);
        chk("first_a_rd", {27'd0, bus.rf_rd}, 5);
        chk("first_a_data", bus.rf_data, 32'hDEADBEEF);
        idle(0, 0, 0, "after_first");

        // Starvation: A wins four times, B forced on the fifth, A resumes
        cyc(1, 10, 32'hA0, 1, 12, 32'hBBBB, 0, 0, 0, 0, 0, 1, 0, 0, "starve1");
        cyc(1, 11, 32'hA1, 1, 12, 32'hBBBB, 0, 0, 0, 0, 0, 1, 0, 0, "starve2");
        cyc(1, 12, 32'hA2, 1, 12, 32'hBBBB, 0, 0, 0, 0, 0, 1, 0, 0, "starve3");
        cyc(1, 13, 32'hA3, 1, 12, 32'hBBBB, 0, 0, 0, 0, 0, 1, 0, 0, "starve4");
        cyc(1, 14, 32'hA4, 1, 12, 32'hBBBB, 0, 0, 0, 0, 0, 0, 1, 0, "starve5");
        cyc(1, 14, 32'hA4, 1, 13, 32'hCCCC, 0, 0, 0, 0, 0, 1, 0, 0, "starve6");
        cyc(1, 15, 32'hA5, 1, 13, 32'hCCCC, 0, 0, 0, 0, 0, 1, 0, 0, "starve7");

        // Stall hold: accepted B write stays on the port until stall drops
        cyc(0, 0, 0, 1, 7, 32'h1234, 0, 0, 0, 0, 0, 1, 1, 0, "stall_acc");
        for (int i = 0; i < 3; i++) begin
            cyc(1, 20, 32'h2020, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, "stall");
            chk("stall_we", {31'd0, bus.rf_we}, 1);
            chk("stall_rd", {27'd0, bus.rf_rd}, 7);
            chk("stall_data", bus.rf_data, 32'h1234);
        end
        idle(0, 0, 0, "stall_release");
        chk("post_stall_we", {31'd0, bus.rf_we}, 0);

        // Write to x0 completes the handshake but never reaches the port
        cyc(1, 0, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, "x0");
        chk("x0_we", {31'd0, bus.rf_we}, 0);
        idle(0, 0, 0, "x0_idle");

        // Scoreboard: issue to 9, B write to 9 retires and clears it
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 9, 9, 0, 1, 0, 0, "sb_issue");
        idle(9, 0, 1, "sb_pend");
        cyc(0, 0, 0, 1, 9, 32'h99, 0, 0, 0, 9, 0, 1, 1, 1, "sb_bacc");
        idle(9, 0, 1, "sb_retire");
        idle(9, 0, 0, "sb_clear");

        // Same-cycle retire and reissue of 9 leaves the bit set
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 9, 9, 0, 1, 0, 0, "sb2_issue");
        cyc(0, 0, 0, 1, 9, 32'h77, 0, 0, 0, 1, 9, 1, 1, 1, "sb2_bacc");
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 9, 9, 0, 1, 0, 1, "sb2_both");
        idle(0, 9, 1, "sb2_kept");
        cyc(0, 0, 0, 1, 9, 32'h66, 0, 0, 0, 0, 9, 1, 1, 1, "sb3_bacc");
        idle(0, 9, 1, "sb3_retire");
        idle(0, 9, 0, "sb3_clear");

        idle(0, 0, 0, "drain");
        chk("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", nchecks, nfail);
        $finish;
    end
endmodule
